// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, store-buffer entry and FSM state types
package mem_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-match search over the queued stores for load forwarding
module sb_fwd_match
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  entry_t            i_entries [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [PTR_W:0]    i_count,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if (((PTR_W+1)'(i) < i_count) && (i_entries[w_idx].addr == i_ld_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write buffer between core memory stage and the data RAM
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  input  logic              flush,
  output logic              flush_done,
  output logic              empty,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  sb_state_e        r_state;
  sb_state_e        w_state_nxt;
  logic             r_flush_done;
  logic             w_accept;
  logic             w_drain;
  logic             w_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign st_ready   = (r_state == RUN) && (r_count < FULL_CNT);
  assign w_accept   = st_valid && st_ready;
  // A load owns the single RAM port, so draining yields to it.
  assign w_drain    = (r_count != '0) && !ld_valid;
  assign empty      = (r_count == '0);
  assign flush_done = r_flush_done;

  assign ram_we    = w_drain;
  assign ram_addr  = ld_valid ? ld_addr : r_entries[r_head].addr;
  assign ram_wdata = r_entries[r_head].data;
  assign ld_data   = w_hit ? w_fwd_data : ram_rdata;

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_ld_addr (ld_addr),
    .o_hit     (w_hit),
    .o_data    (w_fwd_data)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_entries[r_tail] <= '{addr: st_addr, data: st_data};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (flush) w_state_nxt = FLUSH;
      FLUSH:   if (r_count == '0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= RUN;
      r_flush_done <= 1'b0;
    end else begin
      if (w_accept) r_tail <= r_tail + PTR_W'(1);
      if (w_drain)  r_head <= r_head + PTR_W'(1);
      r_count      <= r_count + (PTR_W+1)'(w_accept) - (PTR_W+1)'(w_drain);
      r_state      <= w_state_nxt;
      r_flush_done <= (r_state == FLUSH) && (r_count == '0);
    end
  end

endmodule
